// File: rtl/llac_core_sequencer.sv
// -----------------------------------------------------------------------------
// llac_core_sequencer
//
// Control-plane sequencer for the NUM_CORES audio processing cores.
//   * Takes start/pause/stop/clear-irq commands (one per cycle) from the register
//     block and emits registered one-cycle core_pause/core_stop/core_resume pulses.
//   * Tracks a per-core lifecycle state:
//       IDLE=0, RUN=1, PAUSED=2, STOPPING=3, FAULT=4
//   * Runs a stop timeout per core. A stop ends in IDLE when core_ack is seen, or in
//     FAULT after STOP_TIMEOUT cycles. Either outcome sets the core's sticky irq bit.
//   * Each sample_tick opens a round-robin dispatch round over the cores that were in
//     RUN when the tick arrived. A tick that arrives while a round is still open is
//     dropped and counted in overrun_count.
//
// Optional feature (macro LLAC_SEQ_OVERRUN_IRQ_EN):
//   Adds a sticky overrun flag. It sets on every dropped tick, is ORed into irq_out,
//   and is cleared by a clear command to any core id.
//
// Ports:
//   clk_100mhz, resetn          clock; asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (cmd_ready is combinational)
//   cmd_core_id, cmd_op         target core; op 00=start 01=pause 10=stop 11=clear
//   cmd_err                     one-cycle pulse on an illegal command
//   core_pause/stop/resume      one-cycle per-core control pulses
//   core_ack                    per-core stop acknowledge (level or pulse)
//   core_state                  packed 3-bit state code per core
//   sample_tick                 one strobe per audio frame
//   dispatch_valid/_core_id     dispatch grant, held until dispatch_ready
//   dispatch_ready              grant consumer handshake
//   overrun_count               saturating count of dropped ticks
//   irq_pending, irq_out        sticky per-core interrupts and their OR
// -----------------------------------------------------------------------------
module llac_core_sequencer #(
   parameter int unsigned NUM_CORES     = 4,
   parameter int unsigned STOP_TIMEOUT  = 1024,
   parameter int unsigned CORE_ID_WIDTH = $clog2(NUM_CORES)
) (
   input  logic                     clk_100mhz,
   input  logic                     resetn,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [CORE_ID_WIDTH-1:0] cmd_core_id,
   input  logic [1:0]               cmd_op,
   output logic                     cmd_err,
   output logic [NUM_CORES-1:0]     core_pause,
   output logic [NUM_CORES-1:0]     core_stop,
   output logic [NUM_CORES-1:0]     core_resume,
   input  logic [NUM_CORES-1:0]     core_ack,
   output logic [3*NUM_CORES-1:0]   core_state,
   input  logic                     sample_tick,
   output logic                     dispatch_valid,
   output logic [CORE_ID_WIDTH-1:0] dispatch_core_id,
   input  logic                     dispatch_ready,
   output logic [15:0]              overrun_count,
   output logic [NUM_CORES-1:0]     irq_pending,
   output logic                     irq_out
);

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StRun      = 3'd1,
      StPaused   = 3'd2,
      StStopping = 3'd3,
      StFault    = 3'd4
   } core_st_e;

   localparam logic [1:0] OpStart = 2'b00;
   localparam logic [1:0] OpPause = 2'b01;
   localparam logic [1:0] OpStop  = 2'b10;
   localparam logic [1:0] OpClear = 2'b11;

   localparam int unsigned TimerWidth = (STOP_TIMEOUT > 1) ? $clog2(STOP_TIMEOUT) : 1;
   localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(STOP_TIMEOUT - 1);
   localparam logic [CORE_ID_WIDTH-1:0] LastId = CORE_ID_WIDTH'(NUM_CORES - 1);

   // ---------------------------------------------------------------------------
   // Per-core lifecycle FSM
   // ---------------------------------------------------------------------------
   core_st_e                state_q [NUM_CORES];
   core_st_e                state_d [NUM_CORES];
   logic [TimerWidth-1:0]   timer_q [NUM_CORES];
   logic [TimerWidth-1:0]   timer_d [NUM_CORES];
   logic [NUM_CORES-1:0]    irq_q, irq_d;
   logic [NUM_CORES-1:0]    pause_q, pause_d;
   logic [NUM_CORES-1:0]    stop_q, stop_d;
   logic [NUM_CORES-1:0]    resume_q, resume_d;
   logic                    err_q, err_d;
   logic                    cmd_fire;

   assign cmd_fire = cmd_valid && cmd_ready;

   // State register
   always_ff @(posedge clk_100mhz or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_CORES; i++) begin
            state_q[i] <= StIdle;
            timer_q[i] <= '0;
         end
         irq_q    <= '0;
         pause_q  <= '0;
         stop_q   <= '0;
         resume_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         irq_q    <= irq_d;
         pause_q  <= pause_d;
         stop_q   <= stop_d;
         resume_q <= resume_d;
         err_q    <= err_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      irq_d    = irq_q;
      pause_d  = '0;
      stop_d   = '0;
      resume_d = '0;
      err_d    = 1'b0;

      // A STOPPING core never accepts a command, so the command decode and the
      // stop-completion loop below never write the same core's state.
      if (cmd_fire) begin
         unique case (cmd_op)
            OpStart: begin
               if (state_q[cmd_core_id] == StIdle || state_q[cmd_core_id] == StPaused) begin
                  state_d[cmd_core_id]  = StRun;
                  resume_d[cmd_core_id] = 1'b1;
               end else if (state_q[cmd_core_id] == StFault) begin
                  err_d = 1'b1;
               end
            end
            OpPause: begin
               if (state_q[cmd_core_id] == StRun) begin
                  state_d[cmd_core_id] = StPaused;
                  pause_d[cmd_core_id] = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            OpStop: begin
               if (state_q[cmd_core_id] == StRun || state_q[cmd_core_id] == StPaused) begin
                  state_d[cmd_core_id] = StStopping;
                  timer_d[cmd_core_id] = '0;
                  stop_d[cmd_core_id]  = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            OpClear: begin
               irq_d[cmd_core_id] = 1'b0;
               if (state_q[cmd_core_id] == StFault) begin
                  state_d[cmd_core_id] = StIdle;
               end
            end
         endcase
      end

      // Stop completion runs after the clear so that a set on the same bit wins.
      // An ack takes priority over a timeout in the same cycle.
      for (int i = 0; i < NUM_CORES; i++) begin
         if (state_q[i] == StStopping) begin
            if (core_ack[i]) begin
               state_d[i] = StIdle;
               irq_d[i]   = 1'b1;
            end else if (timer_q[i] == TimerLast) begin
               state_d[i] = StFault;
               irq_d[i]   = 1'b1;
            end else begin
               timer_d[i] = timer_q[i] + 1'b1;
            end
         end
      end
   end

   // Output logic
   always_comb begin
      core_state = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         core_state[3*i +: 3] = state_q[i];
      end
      cmd_ready = (state_q[cmd_core_id] != StStopping);
   end

   assign core_pause  = pause_q;
   assign core_stop   = stop_q;
   assign core_resume = resume_q;
   assign cmd_err     = err_q;
   assign irq_pending = irq_q;

   // ---------------------------------------------------------------------------
   // Round-robin dispatch
   // ---------------------------------------------------------------------------
   // A round is open exactly while a grant is presented: the grants in a round
   // follow each other with no bubble, so dv_q doubles as the round-active flag.
   logic                     dv_q, dv_d;
   logic [CORE_ID_WIDTH-1:0] did_q, did_d;
   logic [NUM_CORES-1:0]     pend_q, pend_d;
   logic [CORE_ID_WIDTH-1:0] ptr_q, ptr_d, ptr_inc;
   logic [15:0]              ovr_q, ovr_d;
   logic [NUM_CORES-1:0]     run_mask, pick_src, pick_mask;
   logic [CORE_ID_WIDTH-1:0] pick_id, idx;
   logic                     pick_found;
   logic                     tick_open, tick_drop, handshake;

   assign tick_open = sample_tick && !dv_q;
   assign tick_drop = sample_tick && dv_q;
   assign handshake = dv_q && dispatch_ready;
   assign ptr_inc   = (ptr_q == LastId) ? '0 : ptr_q + 1'b1;

   always_comb begin
      run_mask = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         run_mask[i] = (state_q[i] == StRun);
      end
   end

   // On a tick the RUN snapshot is searched; mid-round, the not-yet-granted
   // remainder is. Both searches start at the round pointer, which keeps the
   // grants of a round in wrapped ascending order.
   assign pick_src = tick_open ? run_mask : pend_q;

   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      pick_mask  = '0;
      idx        = '0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         idx = CORE_ID_WIDTH'((32'(ptr_q) + i) % NUM_CORES);
         if (!pick_found && pick_src[idx]) begin
            pick_found     = 1'b1;
            pick_id        = idx;
            pick_mask[idx] = 1'b1;
         end
      end
   end

   always_comb begin
      dv_d   = dv_q;
      did_d  = did_q;
      pend_d = pend_q;
      ptr_d  = ptr_q;
      ovr_d  = ovr_q;
      if (tick_open) begin
         if (pick_found) begin
            dv_d   = 1'b1;
            did_d  = pick_id;
            pend_d = run_mask & ~pick_mask;
         end else begin
            // Empty snapshot: the round closes at once but still rotates the pointer.
            ptr_d = ptr_inc;
         end
      end else if (handshake) begin
         if (pick_found) begin
            did_d  = pick_id;
            pend_d = pend_q & ~pick_mask;
         end else begin
            dv_d  = 1'b0;
            ptr_d = ptr_inc;
         end
      end
      if (tick_drop && ovr_q != 16'hFFFF) begin
         ovr_d = ovr_q + 16'd1;
      end
   end

   always_ff @(posedge clk_100mhz or negedge resetn) begin
      if (!resetn) begin
         dv_q   <= 1'b0;
         did_q  <= '0;
         pend_q <= '0;
         ptr_q  <= '0;
         ovr_q  <= '0;
      end else begin
         dv_q   <= dv_d;
         did_q  <= did_d;
         pend_q <= pend_d;
         ptr_q  <= ptr_d;
         ovr_q  <= ovr_d;
      end
   end

   assign dispatch_valid   = dv_q;
   assign dispatch_core_id = did_q;
   assign overrun_count    = ovr_q;

   // ---------------------------------------------------------------------------
   // Interrupt aggregation
   // ---------------------------------------------------------------------------
`ifdef LLAC_SEQ_OVERRUN_IRQ_EN
   logic ovf_flag_q;

   always_ff @(posedge clk_100mhz or negedge resetn) begin
      if (!resetn) begin
         ovf_flag_q <= 1'b0;
      end else if (tick_drop) begin
         ovf_flag_q <= 1'b1;
      end else if (cmd_fire && cmd_op == OpClear) begin
         ovf_flag_q <= 1'b0;
      end
   end

   assign irq_out = (|irq_q) | ovf_flag_q;
`else
   assign irq_out = |irq_q;
`endif

endmodule

// File: tb/tb_llac_core_sequencer.sv
module tb_llac_core_sequencer;

   localparam int N   = 4;
   localparam int TMO = 1024;
   localparam int IW  = 2;

   logic            clk_100mhz = 1'b0;
   logic            resetn = 1'b0;
   logic            cmd_valid = 1'b0;
   logic            cmd_ready;
   logic [IW-1:0]   cmd_core_id = '0;
   logic [1:0]      cmd_op = 2'b00;
   logic            cmd_err;
   logic [N-1:0]    core_pause, core_stop, core_resume;
   logic [N-1:0]    core_ack = '0;
   logic [3*N-1:0]  core_state;
   logic            sample_tick = 1'b0;
   logic            dispatch_valid;
   logic [IW-1:0]   dispatch_core_id;
   logic            dispatch_ready = 1'b0;
   logic [15:0]     overrun_count;
   logic [N-1:0]    irq_pending;
   logic            irq_out;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   llac_core_sequencer #(
      .NUM_CORES    (N),
      .STOP_TIMEOUT (TMO),
      .CORE_ID_WIDTH(IW)
   ) dut (
      .clk_100mhz      (clk_100mhz),
      .resetn          (resetn),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_core_id     (cmd_core_id),
      .cmd_op          (cmd_op),
      .cmd_err         (cmd_err),
      .core_pause      (core_pause),
      .core_stop       (core_stop),
      .core_resume     (core_resume),
      .core_ack        (core_ack),
      .core_state      (core_state),
      .sample_tick     (sample_tick),
      .dispatch_valid  (dispatch_valid),
      .dispatch_core_id(dispatch_core_id),
      .dispatch_ready  (dispatch_ready),
      .overrun_count   (overrun_count),
      .irq_pending     (irq_pending),
      .irq_out         (irq_out)
   );

   always #5 clk_100mhz = ~clk_100mhz;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model: lifecycle table, elapsed-cycle stop counter, and the
   // current round kept as a queue of the grants still owed.
   // ---------------------------------------------------------------------------
   int       m_st  [N];
   int       m_cnt [N];
   bit [N-1:0] m_irq, m_pause, m_stop, m_resume;
   bit       m_err;
   bit       m_ovf;
   int       m_round[$];
   int       m_ptr;
   int       m_ovr;

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_st[i]  = 0;
         m_cnt[i] = 0;
      end
      m_irq = '0; m_pause = '0; m_stop = '0; m_resume = '0;
      m_err = 1'b0; m_ovf = 1'b0;
      m_round.delete();
      m_ptr = 0; m_ovr = 0;
   endtask

   task automatic model_step();
      int st_old[N];
      int id;
      st_old = m_st;
      m_pause = '0; m_stop = '0; m_resume = '0; m_err = 1'b0;

      // dispatch
      if (m_round.size() > 0) begin
         if (sample_tick) begin
            m_ovr = (m_ovr < 65535) ? m_ovr + 1 : 65535;
            m_ovf = 1'b1;
         end
         if (dispatch_ready) begin
            m_round.delete(0);
            if (m_round.size() == 0) m_ptr = (m_ptr + 1) % N;
         end
      end else if (sample_tick) begin
         for (int k = 0; k < N; k++)
            if (st_old[(m_ptr + k) % N] == 1) m_round.push_back((m_ptr + k) % N);
         if (m_round.size() == 0) m_ptr = (m_ptr + 1) % N;
      end

      // command
      id = int'(cmd_core_id);
      if (cmd_valid && st_old[id] != 3) begin
         case (cmd_op)
            2'b00: begin
               if (st_old[id] == 0 || st_old[id] == 2) begin m_st[id] = 1; m_resume[id] = 1'b1; end
               else if (st_old[id] == 4) m_err = 1'b1;
            end
            2'b01: begin
               if (st_old[id] == 1) begin m_st[id] = 2; m_pause[id] = 1'b1; end
               else m_err = 1'b1;
            end
            2'b10: begin
               if (st_old[id] == 1 || st_old[id] == 2) begin
                  m_st[id] = 3; m_stop[id] = 1'b1; m_cnt[id] = 0;
               end else m_err = 1'b1;
            end
            default: begin
               m_irq[id] = 1'b0;
               m_ovf = m_ovf && sample_tick && m_round.size() > 0 ? 1'b1 : 1'b0;
               if (st_old[id] == 4) m_st[id] = 0;
            end
         endcase
      end

      // stop completion, counted in cycles since the stop pulse
      for (int i = 0; i < N; i++) begin
         if (st_old[i] == 3) begin
            m_cnt[i]++;
            if (core_ack[i]) begin m_st[i] = 0; m_irq[i] = 1'b1; end
            else if (m_cnt[i] == TMO) begin m_st[i] = 4; m_irq[i] = 1'b1; end
         end
      end
   endtask

   always @(posedge clk_100mhz or negedge resetn) begin
      if (!resetn) model_reset();
      else model_step();
   end

   // ---------------------------------------------------------------------------
   // Per-cycle compare against the model
   // ---------------------------------------------------------------------------
   logic [3*N-1:0] exp_st;
   bit             exp_irq_out;

   always @(negedge clk_100mhz) begin
      if (cmp_en) begin
         for (int i = 0; i < N; i++) exp_st[3*i +: 3] = 3'(m_st[i]);
`ifdef LLAC_SEQ_OVERRUN_IRQ_EN
         exp_irq_out = (|m_irq) | m_ovf;
`else
         exp_irq_out = |m_irq;
`endif
         check("core_state", 32'(core_state), 32'(exp_st));
         check("cmd_ready", 32'(cmd_ready), 32'(m_st[int'(cmd_core_id)] != 3));
         check("cmd_err", 32'(cmd_err), 32'(m_err));
         check("core_pause", 32'(core_pause), 32'(m_pause));
         check("core_stop", 32'(core_stop), 32'(m_stop));
         check("core_resume", 32'(core_resume), 32'(m_resume));
         check("irq_pending", 32'(irq_pending), 32'(m_irq));
         check("irq_out", 32'(irq_out), 32'(exp_irq_out));
         check("overrun_count", 32'(overrun_count), 32'(m_ovr));
         check("dispatch_valid", 32'(dispatch_valid), 32'(m_round.size() > 0));
         if (m_round.size() > 0)
            check("dispatch_core_id", 32'(dispatch_core_id), 32'(m_round[0]));
      end
   end

   // ---------------------------------------------------------------------------
   // Directed stimulus with literal expectations
   // ---------------------------------------------------------------------------
   task automatic cyc();
      @(posedge clk_100mhz);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input int id);
      cmd_op      = op;
      cmd_core_id = IW'(id);
      cmd_valid   = 1'b1;
      cyc();
      cmd_valid   = 1'b0;
   endtask

   task automatic tick_round(input int g0, input int g1, input int g2);
      int exp_g[3];
      exp_g[0] = g0; exp_g[1] = g1; exp_g[2] = g2;
      sample_tick = 1'b1;
      cyc();
      sample_tick = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("round_valid", 32'(dispatch_valid), 32'd1);
         check("round_grant", 32'(dispatch_core_id), 32'(exp_g[k]));
         cyc();
      end
      check("round_end", 32'(dispatch_valid), 32'd0);
   endtask

   initial begin
      repeat (3) cyc();
      check("rst_state", 32'(core_state), 32'h0);
      check("rst_irq_out", 32'(irq_out), 32'h0);
      check("rst_dv", 32'(dispatch_valid), 32'h0);
      check("rst_ovr", 32'(overrun_count), 32'h0);
      cmp_en = 1'b1;
      resetn = 1'b1;
      cyc();

      // start / pause core 2
      send(2'b00, 2);
      check("start2_resume", 32'(core_resume), 32'h4);
      check("start2_state", 32'(core_state[8:6]), 32'h1);
      cyc();
      check("start2_pulse_gone", 32'(core_resume), 32'h0);
      send(2'b01, 2);
      check("pause2_pulse", 32'(core_pause), 32'h4);
      check("pause2_state", 32'(core_state[8:6]), 32'h2);

      // stop core 1 with ack
      send(2'b00, 1);
      send(2'b10, 1);
      check("stop1_pulse", 32'(core_stop), 32'h2);
      check("stop1_state", 32'(core_state[5:3]), 32'h3);
      check("stop1_ready", 32'(cmd_ready), 32'h0);
      repeat (9) cyc();
      core_ack = 4'b0010;
      cyc();
      core_ack = 4'b0000;
      check("ack1_state", 32'(core_state[5:3]), 32'h0);
      check("ack1_irq", 32'(irq_pending), 32'h2);
      check("ack1_irq_out", 32'(irq_out), 32'h1);
      send(2'b11, 1);
      check("clr1_irq", 32'(irq_pending), 32'h0);
      check("clr1_irq_out", 32'(irq_out), 32'h0);

      // stop core 0 without ack -> FAULT after exactly TMO cycles
      send(2'b00, 0);
      send(2'b10, 0);
      repeat (TMO - 1) cyc();
      check("tmo_still_stopping", 32'(core_state[2:0]), 32'h3);
      check("tmo_ready_low", 32'(cmd_ready), 32'h0);
      cyc();
      check("tmo_fault", 32'(core_state[2:0]), 32'h4);
      check("tmo_irq", 32'(irq_pending), 32'h1);
      send(2'b00, 0);
      check("fault_start_err", 32'(cmd_err), 32'h1);
      check("fault_state_kept", 32'(core_state[2:0]), 32'h4);
      send(2'b11, 0);
      check("fault_clear_idle", 32'(core_state[2:0]), 32'h0);

      // dispatch rounds over cores 0, 1, 3
      send(2'b00, 0);
      send(2'b00, 1);
      send(2'b00, 3);
      dispatch_ready = 1'b1;
      tick_round(0, 1, 3);
      tick_round(1, 3, 0);

      // overrun with consumer stalled
      dispatch_ready = 1'b0;
      sample_tick = 1'b1;
      cyc();
      repeat (3) cyc();
      sample_tick = 1'b0;
      check("ovr_count", 32'(overrun_count), 32'd3);
      check("ovr_valid", 32'(dispatch_valid), 32'h1);
      check("ovr_grant", 32'(dispatch_core_id), 32'd3);
`ifdef LLAC_SEQ_OVERRUN_IRQ_EN
      check("ovr_irq_out", 32'(irq_out), 32'h1);
`else
      check("ovr_irq_out", 32'(irq_out), 32'h0);
`endif
      cyc();
      check("ovr_grant_stable", 32'(dispatch_core_id), 32'd3);
      dispatch_ready = 1'b1;
      repeat (3) cyc();
      check("ovr_round_end", 32'(dispatch_valid), 32'h0);
      send(2'b11, 2);
      check("ovr_cleared_irq", 32'(irq_out), 32'h0);

      // async reset while core 3 is STOPPING and a round is open
      send(2'b10, 3);
      check("stop3_pulse", 32'(core_stop), 32'h8);
      dispatch_ready = 1'b0;
      sample_tick = 1'b1;
      cyc();
      sample_tick = 1'b0;
      check("mid_round_grant", 32'(dispatch_core_id), 32'd0);
      #2 resetn = 1'b0;
      #1;
      check("arst_state", 32'(core_state), 32'h0);
      check("arst_dv", 32'(dispatch_valid), 32'h0);
      check("arst_did", 32'(dispatch_core_id), 32'h0);
      check("arst_ovr", 32'(overrun_count), 32'h0);
      check("arst_irq", 32'(irq_pending), 32'h0);
      check("arst_irq_out", 32'(irq_out), 32'h0);
      check("arst_pulses", 32'({core_pause, core_stop, core_resume}), 32'h0);
      check("arst_err", 32'(cmd_err), 32'h0);
      cyc();
      resetn = 1'b1;
      cyc();

      // pointer restarts at 0 after reset
      send(2'b00, 1);
      dispatch_ready = 1'b1;
      sample_tick = 1'b1;
      cyc();
      sample_tick = 1'b0;
      check("post_rst_grant", 32'(dispatch_core_id), 32'd1);
      check("post_rst_valid", 32'(dispatch_valid), 32'h1);
      cyc();
      check("post_rst_end", 32'(dispatch_valid), 32'h0);
      repeat (3) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
